// File: rtl/ne16_normquant_bias_ctrl.sv
// Normquant bias/shift sequencer: walks a tile's output channels in NADD-wide chunks,
// pairing one parameter beat and one accumulator-bank read with each presented chunk.
module ne16_normquant_bias_ctrl #(
    parameter int NADD            = 8,
    parameter int ACC             = 32,
    parameter int NACC            = 32,
    parameter int OUTPUT_REGISTER = 0,
    localparam int CW             = $clog2(NACC + 1),
    localparam int NCHUNK_MAX     = (NACC + NADD - 1) / NADD,
    localparam int IW             = (NCHUNK_MAX > 1) ? $clog2(NCHUNK_MAX) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [CW-1:0]         nb_chan_i,
    output logic                  busy_o,
    output logic                  done_o,
    input  logic                  param_valid_i,
    output logic                  param_ready_o,
    input  logic [NADD*ACC-1:0]   param_bias_i,
    input  logic [NADD*8-1:0]     param_shift_i,
    output logic [NADD*ACC-1:0]   norm_bias_o,
    output logic [NADD*8-1:0]     shift_o,
    output logic                  dp_clear_o,
    output logic                  acc_rd_o,
    output logic [IW-1:0]         acc_idx_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [NADD-1:0]       out_mask_o,
    output logic                  out_last_o
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        WAIT,
        OUT,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [IW-1:0]       chunk_idx_q;
    logic [IW-1:0]       last_idx_q;
    logic [NADD-1:0]     last_mask_q;
    logic [NADD*ACC-1:0] norm_bias_q;
    logic [NADD*8-1:0]   shift_q;

    logic [IW-1:0]       start_last_idx;
    logic [NADD-1:0]     start_mask;
    logic [31:0]         start_rem;

    logic start_acc;
    logic param_hs;
    logic out_hs;
    logic is_last;

    assign start_acc = (state_q == IDLE) && start_i;
    assign param_hs  = (state_q == LOAD) && param_valid_i;
    assign out_hs    = (state_q == OUT) && out_ready_i;
    assign is_last   = (chunk_idx_q == last_idx_q);

    // Last-chunk index and lane mask are derived once at start so the OUT path stays shallow.
    always_comb begin
        start_last_idx = IW'((32'(nb_chan_i) - 32'd1) / 32'(NADD));
        start_rem      = 32'(nb_chan_i) - 32'(start_last_idx) * 32'(NADD);
        start_mask     = '0;
        for (int l = 0; l < NADD; l++) begin
            start_mask[l] = (32'(l) < start_rem);
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_i) state_d = (nb_chan_i != '0) ? LOAD : DONE;
                LOAD:    if (param_valid_i) state_d = ISSUE;
                ISSUE:   state_d = (OUTPUT_REGISTER != 0) ? WAIT : OUT;
                WAIT:    state_d = OUT;
                OUT:     if (out_ready_i) state_d = is_last ? DONE : LOAD;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            chunk_idx_q <= '0;
            last_idx_q  <= '0;
            last_mask_q <= '0;
        end else if (clear_i) begin
            chunk_idx_q <= '0;
        end else if (start_acc) begin
            chunk_idx_q <= '0;
            last_idx_q  <= start_last_idx;
            last_mask_q <= start_mask;
        end else if (out_hs && !is_last) begin
            chunk_idx_q <= chunk_idx_q + IW'(1);
        end
    end

    // Operands stay put between accepted beats; clear wipes them so a new tile starts clean.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            norm_bias_q <= '0;
            shift_q     <= '0;
        end else if (clear_i) begin
            norm_bias_q <= '0;
            shift_q     <= '0;
        end else if (param_hs) begin
            norm_bias_q <= param_bias_i;
            shift_q     <= param_shift_i;
        end
    end

    assign busy_o        = (state_q != IDLE);
    assign done_o        = (state_q == DONE);
    assign param_ready_o = (state_q == LOAD);
    assign norm_bias_o   = norm_bias_q;
    assign shift_o       = shift_q;
    assign dp_clear_o    = clear_i || start_acc;
    assign acc_rd_o      = (state_q == ISSUE);
    assign acc_idx_o     = chunk_idx_q;
    assign out_valid_o   = (state_q == OUT);
    assign out_last_o    = out_valid_o && is_last;
    assign out_mask_o    = out_valid_o ? (is_last ? last_mask_q : '1) : '0;

endmodule

// File: doc/ne16_normquant_bias_ctrl.md
# ne16_normquant_bias_ctrl

Sequencer for the normquant bias/shift stage. On `start_i` it walks the output channels of a tile in NADD-wide chunks. For each chunk it:
- accepts one bias/shift parameter beat from the streamer,
- issues one accumulator-bank read,
- waits for the bias/shift datapath latency,
- presents the normalized chunk on a valid/ready output with lane mask and last flag.

It sits between the weight/param streamer, the accumulator bank and the bias/shift datapath, and drives the datapath's `norm_bias` and `shift` operands.

## Interface
- NADD, 8, lanes per chunk
- ACC, 32, accumulator/bias width per lane
- NACC, 32, max output channels per tile
- OUTPUT_REGISTER, 0, datapath pipeline depth (0 or 1)
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous soft clear, highest priority
- start_i  in  1  start pulse, sampled only in IDLE
- nb_chan_i  in  $clog2(NACC+1)  valid output channels, sampled with start_i
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse at tile end
- param_valid_i  in  1  parameter beat valid
- param_ready_o  out  1  high only in LOAD
- param_bias_i  in  NADD*ACC  per-lane bias
- param_shift_i  in  NADD*8  per-lane shift
- norm_bias_o  out  NADD*ACC  registered bias to datapath
- shift_o  out  NADD*8  registered shift to datapath
- dp_clear_o  out  1  datapath clear
- acc_rd_o  out  1  bank read strobe
- acc_idx_o  out  max(1,$clog2(ceil(NACC/NADD)))  chunk index
- out_valid_o  out  1  normalized chunk valid
- out_ready_i  in  1  consumer ready
- out_mask_o  out  NADD  valid-lane mask
- out_last_o  out  1  final chunk of tile

## Operation
- States: IDLE, LOAD, ISSUE, WAIT, OUT, DONE.
- IDLE:
  - On start_i with nb_chan_i≠0: latch nb_chan, nchunk = ceil(nb_chan/NADD), chunk_idx = 0, go to LOAD.
  - On start_i with nb_chan_i=0: go directly to DONE, with no parameter or bank traffic.
- LOAD:
  - param_ready_o = 1.
  - On handshake: register param_bias_i into norm_bias_o and param_shift_i into shift_o, go to ISSUE.
  - Both outputs hold their value until the next accepted beat.
- ISSUE: acc_rd_o = 1 and acc_idx_o = chunk_idx, for exactly one cycle.
  - If OUTPUT_REGISTER=0, go to OUT.
  - If OUTPUT_REGISTER=1, go to WAIT.
- WAIT: one cycle, then go to OUT.
- OUT: out_valid_o = 1.
  - On out_ready_i with chunk_idx = nchunk-1: go to DONE.
  - On out_ready_i otherwise: chunk_idx++, go to LOAD.
- DONE: done_o = 1 for one cycle, then go to IDLE.
- Lane mask:
  - out_mask_o is all ones except on the last chunk.
  - Last chunk: out_mask_o = (1<<r)-1, where r = nb_chan - (nchunk-1)*NADD, 1≤r≤NADD.
  - out_last_o = out_valid_o && chunk_idx = nchunk-1.
- dp_clear_o = clear_i, or an accepted start in IDLE.
- clear_i:
  - In any state: next state is IDLE and chunk_idx = 0.
  - norm_bias_o and shift_o are zeroed.
  - No done_o pulse is produced.
- start_i outside IDLE is ignored.
- The bank holds its read data until the next acc_rd_o. The controller issues no read while in OUT, so the presented data stays stable under backpressure.

## Timing
- Every output resets to 0: busy_o, done_o, param_ready_o, norm_bias_o, shift_o, dp_clear_o, acc_rd_o, acc_idx_o, out_valid_o, out_mask_o, out_last_o.
- Bank read latency is 1 cycle. Datapath latency is OUTPUT_REGISTER cycles. A result is valid 1+OUTPUT_REGISTER cycles after ISSUE, which is the first OUT cycle.
- Minimum cycles per chunk are 3+OUTPUT_REGISTER: LOAD, ISSUE, [WAIT], OUT.
- No overlap between chunks: the next parameter beat is accepted only after the OUT handshake.
- With start at cycle 0, LOAD is cycle 1.
- out_valid_o must not drop before the handshake. While it is high, out_mask_o, out_last_o and acc_idx_o must not change.
- Simultaneous clear_i and handshake (param or out): clear wins and the handshake is discarded.
- Simultaneous clear_i and start_i in IDLE: stay in IDLE.
- An asynchronous reset mid-tile returns the block to IDLE with all outputs at 0.

## Test plan
- Full tile, no stalls (NADD=8, NACC=32, nb_chan=32, OUTPUT_REGISTER=0, params always valid, out_ready=1; start at cycle 0) -> acc_idx 0,1,2,3 read at cycles 2,5,8,11. OUT at cycles 3,6,9,12, each with mask 0xFF. out_last at cycle 12. done_o at cycle 13. busy_o low at cycle 14.
- Partial tile (nb_chan=13) -> 2 chunks with masks 0xFF then 0x1F; out_last only on the second chunk.
- Output backpressure (out_ready low for 5 cycles in the first OUT) -> out_valid, mask and idx held stable; param_ready_o and acc_rd_o stay 0; flow resumes 1 cycle after ready.
- Parameter stall (param_valid low for 4 cycles in LOAD) -> the FSM stays in LOAD; norm_bias_o and shift_o change only the cycle after the handshake; the loaded bias 0x0000_0100 and shift 3 appear on all lanes.
- clear_i asserted in OUT of chunk 1 -> next cycle is IDLE with busy 0, out_valid 0 and no done_o. A following start with nb_chan=8 completes normally.
- Edge cases:
  - nb_chan=0 -> done_o one cycle after start, with no param_ready or acc_rd.
  - OUTPUT_REGISTER=1 with nb_chan=16 -> 4 cycles per chunk; done_o at cycle 9.
